// File: rtl/rv_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: hazard sources in, stage controls out.
interface rv_hazard_ctrl_if;
  logic        i_dec_valid;
  logic [4:0]  i_dec_rs1;
  logic [4:0]  i_dec_rs2;
  logic        i_dec_rs1_used;
  logic        i_dec_rs2_used;
  logic        i_ex_valid;
  logic        i_ex_load;
  logic [4:0]  i_ex_rd;
  logic        i_ex_redirect;
  logic        i_trap;
  logic        i_mc_start;
  logic        i_mc_done;
  logic        o_fetch_stall;
  logic        o_dec_stall;
  logic        o_ex_stall;
  logic        o_dec_flush;
  logic        o_ex_flush;
  logic        o_mc_abort;
  logic        o_mc_timeout;
  logic [1:0]  o_state;
  logic [31:0] o_stall_cycles;

  modport master (
    output i_dec_valid, i_dec_rs1, i_dec_rs2, i_dec_rs1_used, i_dec_rs2_used,
    output i_ex_valid, i_ex_load, i_ex_rd, i_ex_redirect, i_trap,
    output i_mc_start, i_mc_done,
    input  o_fetch_stall, o_dec_stall, o_ex_stall, o_dec_flush, o_ex_flush,
    input  o_mc_abort, o_mc_timeout, o_state, o_stall_cycles
  );

  modport slave (
    input  i_dec_valid, i_dec_rs1, i_dec_rs2, i_dec_rs1_used, i_dec_rs2_used,
    input  i_ex_valid, i_ex_load, i_ex_rd, i_ex_redirect, i_trap,
    input  i_mc_start, i_mc_done,
    output o_fetch_stall, o_dec_stall, o_ex_stall, o_dec_flush, o_ex_flush,
    output o_mc_abort, o_mc_timeout, o_state, o_stall_cycles
  );
endinterface

// File: rtl/rv_hazard_ctrl.sv
// In-order pipeline hazard controller: load-use stalls, multi-cycle EX waits,
// and redirect/trap flushes, with a running count of decode-stall cycles.
module rv_hazard_ctrl #(
  parameter int LOAD_LAT   = 1,
  parameter int FLUSH_LEN  = 2,
  parameter int MC_TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  rv_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    MC    = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Counters are preloaded with "remaining cycles minus one" so the exit test is a zero compare.
  localparam logic [1:0] LD_INIT   = (LOAD_LAT > 1)  ? 2'(LOAD_LAT - 2)  : 2'd0;
  localparam logic [1:0] FL_INIT   = (FLUSH_LEN > 1) ? 2'(FLUSH_LEN - 2) : 2'd0;
  localparam state_t     FLUSH_TGT = (FLUSH_LEN > 1) ? FLUSH : RUN;
  localparam state_t     LD_TGT    = (LOAD_LAT > 1)  ? LDUSE : RUN;
  localparam logic [7:0] MC_LIMIT  = 8'(MC_TIMEOUT);

  state_t      state, state_nxt;
  logic [1:0]  ld_cnt, ld_cnt_nxt;
  logic [1:0]  fl_cnt, fl_cnt_nxt;
  logic [7:0]  mc_cnt, mc_cnt_nxt;
  logic [31:0] stall_cycles;

  logic fetch_stall, dec_stall, ex_stall;
  logic dec_flush, ex_flush, mc_abort, mc_timeout;

  function automatic logic load_use(
    input logic       dec_valid,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       rs1_used,
    input logic       rs2_used,
    input logic       ex_valid,
    input logic       ex_load,
    input logic [4:0] rd
  );
    return dec_valid && ex_valid && ex_load && (rd != 5'd0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

  logic hazard, trap, redirect, mc_start, mc_done, mc_expired;

  assign hazard     = load_use(bus.i_dec_valid, bus.i_dec_rs1, bus.i_dec_rs2,
                               bus.i_dec_rs1_used, bus.i_dec_rs2_used,
                               bus.i_ex_valid, bus.i_ex_load, bus.i_ex_rd);
  assign trap       = bus.i_trap;
  assign redirect   = bus.i_ex_redirect;
  assign mc_start   = bus.i_mc_start;
  assign mc_done    = bus.i_mc_done;
  assign mc_expired = (mc_cnt == MC_LIMIT);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state        <= RUN;
      ld_cnt       <= 2'd0;
      fl_cnt       <= 2'd0;
      mc_cnt       <= 8'd0;
      stall_cycles <= 32'd0;
    end else begin
      state        <= state_nxt;
      ld_cnt       <= ld_cnt_nxt;
      fl_cnt       <= fl_cnt_nxt;
      mc_cnt       <= mc_cnt_nxt;
      stall_cycles <= stall_cycles + {31'd0, dec_stall};
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_cnt_nxt = ld_cnt;
    fl_cnt_nxt = fl_cnt;
    mc_cnt_nxt = mc_cnt;
    case (state)
      RUN: begin
        if (trap || redirect) begin
          state_nxt  = FLUSH_TGT;
          fl_cnt_nxt = FL_INIT;
        end else if (mc_start) begin
          state_nxt  = MC;
          mc_cnt_nxt = 8'd0;
        end else if (hazard) begin
          state_nxt  = LD_TGT;
          ld_cnt_nxt = LD_INIT;
        end
      end
      LDUSE: begin
        if (trap || redirect) begin
          state_nxt  = FLUSH_TGT;
          fl_cnt_nxt = FL_INIT;
        end else if (ld_cnt == 2'd0) begin
          state_nxt = RUN;
        end else begin
          ld_cnt_nxt = ld_cnt - 2'd1;
        end
      end
      MC: begin
        // A redirect cannot come from EX while EX is busy with the multi-cycle op.
        if (trap) begin
          state_nxt  = FLUSH_TGT;
          fl_cnt_nxt = FL_INIT;
        end else if (mc_done || mc_expired) begin
          state_nxt = RUN;
        end else begin
          mc_cnt_nxt = mc_cnt + 8'd1;
        end
      end
      FLUSH: begin
        if (trap || redirect) begin
          fl_cnt_nxt = FL_INIT;
        end else if (fl_cnt == 2'd0) begin
          state_nxt = RUN;
        end else begin
          fl_cnt_nxt = fl_cnt - 2'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Controls are gated by reset so nothing leaks out while the pipeline is being cleared.
  always_comb begin
    fetch_stall = 1'b0;
    dec_stall   = 1'b0;
    ex_stall    = 1'b0;
    dec_flush   = 1'b0;
    ex_flush    = 1'b0;
    mc_abort    = 1'b0;
    mc_timeout  = 1'b0;
    if (i_reset_n) begin
      case (state)
        RUN: begin
          if (trap || redirect) begin
            dec_flush = 1'b1;
            ex_flush  = 1'b1;
          end else if (!mc_start && hazard) begin
            fetch_stall = 1'b1;
            dec_stall   = 1'b1;
            ex_flush    = 1'b1;
          end
        end
        LDUSE: begin
          if (trap || redirect) begin
            dec_flush = 1'b1;
            ex_flush  = 1'b1;
          end else begin
            fetch_stall = 1'b1;
            dec_stall   = 1'b1;
            ex_flush    = 1'b1;
          end
        end
        MC: begin
          if (trap) begin
            dec_flush = 1'b1;
            ex_flush  = 1'b1;
            mc_abort  = 1'b1;
          end else if (!mc_done) begin
            fetch_stall = 1'b1;
            dec_stall   = 1'b1;
            ex_stall    = 1'b1;
            mc_timeout  = mc_expired;
          end
        end
        FLUSH: begin
          dec_flush = 1'b1;
          ex_flush  = trap || redirect;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_fetch_stall  = fetch_stall;
  assign bus.o_dec_stall    = dec_stall;
  assign bus.o_ex_stall     = ex_stall;
  assign bus.o_dec_flush    = dec_flush;
  assign bus.o_ex_flush     = ex_flush;
  assign bus.o_mc_abort     = mc_abort;
  assign bus.o_mc_timeout   = mc_timeout;
  assign bus.o_state        = state;
  assign bus.o_stall_cycles = stall_cycles;

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Two controller configurations driven by one stimulus stream and compared against a cycle model.
module tb_rv_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic       dv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       exv;
    logic       exl;
    logic [4:0] rd;
    logic       redir;
    logic       trap;
    logic       mcs;
    logic       mcd;
  } stim_t;

  typedef struct packed {
    logic        fs;
    logic        ds;
    logic        es;
    logic        df;
    logic        ef;
    logic        ab;
    logic        to;
    logic [1:0]  st;
    logic [31:0] cyc;
  } out_t;

  logic  clk = 1'b0;
  stim_t s   = '0;
  out_t  obs [2];

  always #5 clk = ~clk;

  // Unit 0: LOAD_LAT=3, FLUSH_LEN=2, MC_TIMEOUT=10. Unit 1: LOAD_LAT=1, FLUSH_LEN=1, MC_TIMEOUT=4.
  for (genvar k = 0; k < 2; k++) begin : g_dut
    rv_hazard_ctrl_if bus ();
    assign bus.i_dec_valid    = s.dv;
    assign bus.i_dec_rs1      = s.rs1;
    assign bus.i_dec_rs2      = s.rs2;
    assign bus.i_dec_rs1_used = s.u1;
    assign bus.i_dec_rs2_used = s.u2;
    assign bus.i_ex_valid     = s.exv;
    assign bus.i_ex_load      = s.exl;
    assign bus.i_ex_rd        = s.rd;
    assign bus.i_ex_redirect  = s.redir;
    assign bus.i_trap         = s.trap;
    assign bus.i_mc_start     = s.mcs;
    assign bus.i_mc_done      = s.mcd;

    rv_hazard_ctrl #(
      .LOAD_LAT  (k == 0 ? 3 : 1),
      .FLUSH_LEN (k == 0 ? 2 : 1),
      .MC_TIMEOUT(k == 0 ? 10 : 4)
    ) dut (
      .i_clk    (clk),
      .i_reset_n(s.rst_n),
      .bus      (bus)
    );

    assign obs[k] = {bus.o_fetch_stall, bus.o_dec_stall, bus.o_ex_stall,
                     bus.o_dec_flush, bus.o_ex_flush, bus.o_mc_abort,
                     bus.o_mc_timeout, bus.o_state, bus.o_stall_cycles};
  end

  int total = 0;
  int bad   = 0;
  bit mdl_ok = 1'b0;

  // Model state: mode 0=run 1=load-use 2=multi-cycle 3=flush; *_left are cycles still owed.
  int          m_mode [2], m_ld_left [2], m_fl_left [2], m_waited [2];
  int          n_mode [2], n_ld_left [2], n_fl_left [2], n_waited [2];
  logic [31:0] m_cyc [2], n_cyc [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic stim_t quiet();
    stim_t q = '0;
    q.rst_n = 1'b1;
    return q;
  endfunction

  task automatic model_eval(input int k, input stim_t st, output out_t e);
    int ll = (k == 0) ? 3 : 1;
    int fl = (k == 0) ? 2 : 1;
    int mt = (k == 0) ? 10 : 4;
    bit hz;
    bit go_flush = 1'b0;
    e = '0;
    e.st  = 2'(m_mode[k]);
    e.cyc = m_cyc[k];
    n_mode[k]    = m_mode[k];
    n_ld_left[k] = m_ld_left[k];
    n_fl_left[k] = m_fl_left[k];
    n_waited[k]  = m_waited[k];
    if (!st.rst_n) begin
      n_mode[k] = 0; n_ld_left[k] = 0; n_fl_left[k] = 0; n_waited[k] = 0;
      n_cyc[k] = 32'd0;
    end else begin
      hz = st.dv && st.exv && st.exl && (st.rd != 0) &&
           ((st.u1 && st.rs1 == st.rd) || (st.u2 && st.rs2 == st.rd));
      case (m_mode[k])
        0: begin
          if (st.trap || st.redir) begin
            e.df = 1; e.ef = 1; go_flush = 1;
          end else if (st.mcs) begin
            n_mode[k] = 2; n_waited[k] = 0;
          end else if (hz) begin
            e.fs = 1; e.ds = 1; e.ef = 1;
            if (ll > 1) begin n_mode[k] = 1; n_ld_left[k] = ll - 1; end
          end
        end
        1: begin
          if (st.trap || st.redir) begin
            e.df = 1; e.ef = 1; go_flush = 1;
          end else begin
            e.fs = 1; e.ds = 1; e.ef = 1;
            n_ld_left[k] = m_ld_left[k] - 1;
            if (n_ld_left[k] == 0) n_mode[k] = 0;
          end
        end
        2: begin
          if (st.trap) begin
            e.df = 1; e.ef = 1; e.ab = 1; go_flush = 1;
          end else if (st.mcd) begin
            n_mode[k] = 0;
          end else if (m_waited[k] == mt) begin
            e.fs = 1; e.ds = 1; e.es = 1; e.to = 1;
            n_mode[k] = 0;
          end else begin
            e.fs = 1; e.ds = 1; e.es = 1;
            n_waited[k] = m_waited[k] + 1;
          end
        end
        default: begin
          e.df = 1;
          if (st.trap || st.redir) begin
            e.ef = 1; n_fl_left[k] = fl - 1;
          end else begin
            n_fl_left[k] = m_fl_left[k] - 1;
            if (n_fl_left[k] == 0) n_mode[k] = 0;
          end
        end
      endcase
      if (go_flush) begin
        if (fl > 1) begin n_mode[k] = 3; n_fl_left[k] = fl - 1; end
        else n_mode[k] = 0;
      end
      n_cyc[k] = m_cyc[k] + (e.ds ? 32'd1 : 32'd0);
    end
  endtask

  task automatic step(input stim_t st);
    out_t e;
    @(negedge clk);
    s = st;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, st, e);
      check_val($sformatf("u%0d.fetch_stall", k), 32'(obs[k].fs), 32'(e.fs));
      check_val($sformatf("u%0d.dec_stall", k),   32'(obs[k].ds), 32'(e.ds));
      check_val($sformatf("u%0d.ex_stall", k),    32'(obs[k].es), 32'(e.es));
      check_val($sformatf("u%0d.dec_flush", k),   32'(obs[k].df), 32'(e.df));
      check_val($sformatf("u%0d.ex_flush", k),    32'(obs[k].ef), 32'(e.ef));
      check_val($sformatf("u%0d.mc_abort", k),    32'(obs[k].ab), 32'(e.ab));
      check_val($sformatf("u%0d.mc_timeout", k),  32'(obs[k].to), 32'(e.to));
      if (mdl_ok) begin
        check_val($sformatf("u%0d.state", k),        32'(obs[k].st), 32'(e.st));
        check_val($sformatf("u%0d.stall_cycles", k), obs[k].cyc,     e.cyc);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_mode[k]    = n_mode[k];
      m_ld_left[k] = n_ld_left[k];
      m_fl_left[k] = n_fl_left[k];
      m_waited[k]  = n_waited[k];
      m_cyc[k]     = n_cyc[k];
    end
    if (!st.rst_n) mdl_ok = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(quiet());
  endtask

  initial begin
    stim_t t;
    t = quiet(); t.rst_n = 1'b0;
    t.trap = 1'b1; t.mcs = 1'b1;
    step(t); step(t);

    // Load-use on x5, then the same shape targeting x0.
    t = quiet(); t.dv = 1; t.exv = 1; t.exl = 1; t.rd = 5'd5; t.rs1 = 5'd5; t.u1 = 1;
    step(t); idle(4);
    t.rd = 5'd0; t.rs1 = 5'd0;
    step(t); idle(1);

    // Redirect coinciding with a hazard.
    t = quiet(); t.dv = 1; t.exv = 1; t.exl = 1; t.rd = 5'd7; t.rs2 = 5'd7; t.u2 = 1; t.redir = 1;
    step(t); idle(3);

    // Multi-cycle op finishing after six stalled cycles, then one that never finishes.
    t = quiet(); t.mcs = 1; step(t); idle(6);
    t = quiet(); t.mcd = 1; step(t); idle(1);
    t = quiet(); t.mcs = 1; step(t); idle(14);

    // Trap during a multi-cycle op, then reset landing inside a flush.
    t = quiet(); t.mcs = 1; step(t); idle(1);
    t = quiet(); t.trap = 1; step(t);
    t = quiet(); t.redir = 1; step(t);
    t = quiet(); t.rst_n = 0; t.redir = 1; step(t);
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      t.rst_n = ($urandom_range(0, 99) != 0);
      t.dv    = ($urandom_range(0, 3) != 0);
      t.rs1   = 5'($urandom_range(0, 3));
      t.rs2   = 5'($urandom_range(0, 3));
      t.u1    = 1'($urandom);
      t.u2    = 1'($urandom);
      t.exv   = ($urandom_range(0, 3) != 0);
      t.exl   = 1'($urandom);
      t.rd    = 5'($urandom_range(0, 3));
      t.redir = ($urandom_range(0, 19) == 0);
      t.trap  = ($urandom_range(0, 29) == 0);
      t.mcs   = ($urandom_range(0, 9) == 0);
      t.mcd   = ($urandom_range(0, 7) == 0);
      step(t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
